// File: rtl/rfft_pkg.sv
// rfft_pkg: shared constants, storage-map field positions, FSM state type
// and the bit-reverse helper used by the RFFT core and its unload reader.
package rfft_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int ADDR_W_DEF = 6;
  localparam int NPTS_DEF   = 256;

  // Storage index j: bank select in [7:6], per-bank address in [5:0].
  localparam int BANK_HI = 7;
  localparam int BANK_LO = 6;
  localparam int ADDR_HI = 5;
  localparam int ADDR_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } unload_state_t;

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

endpackage

// File: rtl/rfft_unload_if.sv
// rfft_unload_if: output stream of the unload block.
// A beat transfers on a rising edge where m_valid && m_ready; while m_valid
// is high and m_ready low the source holds m_data/m_index/m_last stable and
// may not withdraw m_valid.
interface rfft_unload_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] m_data;
  logic [7:0]       m_index;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (output m_data, m_index, m_valid, m_last, input m_ready);
  modport slave  (input m_data, m_index, m_valid, m_last, output m_ready);
endinterface

// File: rtl/rfft_unload_fifo2.sv
// rfft_unload_fifo2: 2-entry synchronous FIFO, first-word fall-through head.
// Push on a full FIFO is accepted only when a pop happens in the same cycle.
module rfft_unload_fifo2 #(
  parameter int DW = 41
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    if (do_push && !do_pop)      count_d = count_q + 2'd1;
    else if (!do_push && do_pop) count_d = count_q - 2'd1;
  end

  // Storage and pointer registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/rfft_unload.sv
// rfft_unload: reads the 256 results of the 4-bank RFFT core and streams
// them out one per cycle with bin index and m_last on the final beat.
// Build option RFFT_UNLOAD_BITREV_EN: when defined, reads follow j =
// bitrev8(k) so output is in natural bin order; when undefined, reads follow
// raw storage order and m_index = bitrev8(j) reports the true bin.
module rfft_unload
  import rfft_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  output logic              busy,
  output logic              finished,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  input  logic [WIDTH-1:0]  ram_out0,
  input  logic [WIDTH-1:0]  ram_out1,
  input  logic [WIDTH-1:0]  ram_out2,
  input  logic [WIDTH-1:0]  ram_out3,
  rfft_unload_if.master     m,
  output unload_state_t     dbg_state
);

  localparam int         NPTS   = 4 << ADDR_W;
  localparam logic [7:0] K_LAST = 8'(NPTS - 1);
  localparam int         DW     = WIDTH + 9;

  unload_state_t state_q, state_d;
  logic [7:0]    k_rd_q, k_rd_d;
  logic          inf_vld_q, inf_vld_d;
  logic [1:0]    inf_bank_q, inf_bank_d;
  logic [7:0]    inf_idx_q, inf_idx_d;
  logic          inf_last_q, inf_last_d;
  logic          finished_q, finished_d;

  logic [7:0]    rd_j, rd_idx;
  logic          pop, issue;
  logic [2:0]    in_use, limit;
  logic [WIDTH-1:0] bank_data;
  logic [DW-1:0] fifo_head;
  logic          fifo_full, fifo_empty;
  logic [1:0]    fifo_count;

`ifdef RFFT_UNLOAD_BITREV_EN
  assign rd_j   = bitrev8(k_rd_q);
  assign rd_idx = k_rd_q;
`else
  assign rd_j   = k_rd_q;
  assign rd_idx = bitrev8(k_rd_q);
`endif

  // Both bank pairs share the per-bank address; the bank is picked on return.
  assign rd_addr0 = rd_j[ADDR_HI:ADDR_LO];
  assign rd_addr1 = rd_j[ADDR_HI:ADDR_LO];

  // A pop this cycle frees one slot, which keeps 1 beat/cycle with ready high.
  assign pop    = m.m_valid && m.m_ready;
  assign in_use = 3'(fifo_count) + 3'(inf_vld_q);
  assign limit  = 3'd2 + 3'(pop);
  assign issue  = (state_q == ST_READ) && (!fifo_full || pop) && (in_use < limit);

  // FSM next-state, issue counter and in-flight pipe.
  always_comb begin
    state_d    = state_q;
    k_rd_d     = k_rd_q;
    inf_vld_d  = issue;
    inf_bank_d = inf_bank_q;
    inf_idx_d  = inf_idx_q;
    inf_last_d = inf_last_q;
    finished_d = 1'b0;
    if (issue) begin
      inf_bank_d = rd_j[BANK_HI:BANK_LO];
      inf_idx_d  = rd_idx;
      inf_last_d = (k_rd_q == K_LAST);
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          k_rd_d  = 8'd0;
        end
      end
      ST_READ: begin
        if (issue) begin
          if (k_rd_q == K_LAST) state_d = ST_DRAIN;
          else                  k_rd_d  = k_rd_q + 8'd1;
        end
      end
      ST_DRAIN: begin
        if (pop && m.m_last) begin
          state_d    = ST_IDLE;
          finished_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and in-flight registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      k_rd_q     <= 8'd0;
      inf_vld_q  <= 1'b0;
      inf_bank_q <= 2'd0;
      inf_idx_q  <= 8'd0;
      inf_last_q <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_rd_q     <= k_rd_d;
      inf_vld_q  <= inf_vld_d;
      inf_bank_q <= inf_bank_d;
      inf_idx_q  <= inf_idx_d;
      inf_last_q <= inf_last_d;
      finished_q <= finished_d;
    end
  end

  // Select the returning bank for the read issued last cycle.
  always_comb begin
    bank_data = ram_out0;
    case (inf_bank_q)
      2'd0: bank_data = ram_out0;
      2'd1: bank_data = ram_out1;
      2'd2: bank_data = ram_out2;
      2'd3: bank_data = ram_out3;
      default: bank_data = ram_out0;
    endcase
  end

  rfft_unload_fifo2 #(.DW(DW)) u_fifo (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .push_i      (inf_vld_q),
    .push_data_i ({inf_last_q, inf_idx_q, bank_data}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign m.m_data   = fifo_head[WIDTH-1:0];
  assign m.m_index  = fifo_head[WIDTH+7:WIDTH];
  assign m.m_last   = fifo_head[WIDTH+8];
  assign m.m_valid  = !fifo_empty;

  assign busy      = (state_q != ST_IDLE);
  assign finished  = finished_q;
  assign dbg_state = state_q;

endmodule
